// File: rtl/grid_loader_pkg.sv
// Shared constants and types for the ASCII grid loader: character codes,
// FSM state encoding and the address field split.
package grid_loader_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int COL_W_DEF  = 8;

  // Row field takes whatever address bits the column field leaves over.
  function automatic int row_width(input int addr_w, input int col_w);
    return addr_w - col_w;
  endfunction

  localparam logic [7:0] CH_ROLL  = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    LOAD,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/grid_loader_if.sv
// Bundle of the character stream input, the grid RAM write port and the
// load status returned to downstream scan stages.
interface grid_loader_if
  import grid_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = COL_W_DEF
);
  localparam int ROW_W = row_width(ADDR_W, COL_W);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] write_addr;
  logic              write_val;
  logic              write_en;
  logic [COL_W:0]    width;
  logic [ROW_W:0]    height;
  logic              done;
  logic              error;

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, write_addr, write_val, write_en, width, height, done, error
  );

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, write_addr, write_val, write_en, width, height, done, error
  );

endinterface

// File: rtl/grid_loader.sv
// Parses an ASCII '@'/'.' grid, one character per beat, into 1-bit writes at
// {row, col} and measures the grid dimensions; malformed input aborts the load.
module grid_loader
  import grid_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COL_W  = COL_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  grid_loader_if.slave   bus
);
  localparam int ROW_W = row_width(ADDR_W, COL_W);
  localparam logic [COL_W:0] COL_LAST = {1'b0, {COL_W{1'b1}}};

  state_t            r_state;
  logic [COL_W:0]    r_col;
  logic [ROW_W:0]    r_row;
  logic [COL_W:0]    r_width;
  logic [ROW_W:0]    r_height;
  logic              r_width_known;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_val;

  state_t            w_state_nxt;
  logic [COL_W:0]    w_col_nxt;
  logic [ROW_W:0]    w_row_nxt;
  logic [COL_W:0]    w_width_nxt;
  logic [ROW_W:0]    w_height_nxt;
  logic              w_width_known_nxt;
  logic              w_wr_en_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic              w_wr_val_nxt;
  logic              w_accept;
  logic              w_fail;
  logic              w_close;

  assign w_accept = bus.in_valid & bus.in_ready;

  always_comb begin
    w_state_nxt       = r_state;
    w_col_nxt         = r_col;
    w_row_nxt         = r_row;
    w_width_nxt       = r_width;
    w_height_nxt      = r_height;
    w_width_known_nxt = r_width_known;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_val_nxt      = r_wr_val;
    w_fail            = 1'b0;
    w_close           = 1'b0;

    if (w_accept) begin
      case (bus.in_data)
        CH_ROLL, CH_EMPTY: begin
          // Row field already past its top value means the address would wrap.
          if (r_col == COL_LAST || (r_width_known && r_col == r_width) || r_row[ROW_W]) begin
            w_fail = 1'b1;
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = {r_row[ROW_W-1:0], r_col[COL_W-1:0]};
            w_wr_val_nxt  = (bus.in_data == CH_ROLL);
            w_col_nxt     = r_col + 1'b1;
          end
        end
        CH_NL:   w_close = (r_col != '0);
        CH_CR:   ;
        default: w_fail = 1'b1;
      endcase

      // An unterminated final row is closed exactly as if '\n' had followed.
      if (!w_fail && bus.in_last && w_col_nxt != '0) begin
        w_close = 1'b1;
      end

      if (w_close) begin
        if (!r_width_known) begin
          w_width_nxt       = w_col_nxt;
          w_width_known_nxt = 1'b1;
        end else if (w_col_nxt != r_width) begin
          w_fail = 1'b1;
        end
        if (!w_fail) begin
          w_height_nxt = r_row + 1'b1;
          w_row_nxt    = r_row + 1'b1;
          w_col_nxt    = '0;
        end
      end

      if (w_fail) begin
        w_state_nxt = ERROR;
      end else if (bus.in_last) begin
        w_state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= LOAD;
      r_col         <= '0;
      r_row         <= '0;
      r_width       <= '0;
      r_height      <= '0;
      r_width_known <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_val      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_width       <= w_width_nxt;
      r_height      <= w_height_nxt;
      r_width_known <= w_width_known_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_val      <= w_wr_val_nxt;
    end
  end

  assign bus.in_ready   = (r_state == LOAD);
  assign bus.write_en   = r_wr_en;
  assign bus.write_addr = r_wr_addr;
  assign bus.write_val  = r_wr_val;
  assign bus.width      = r_width;
  assign bus.height     = r_height;
  assign bus.done       = (r_state == DONE);
  assign bus.error      = (r_state == ERROR);

endmodule

// File: tb/tb_grid_loader.sv
// Randomised scoreboard bench for grid_loader: a row-oriented reference model
// predicts every RAM write and the final status of each character stream.
module tb_grid_loader;
  import grid_loader_pkg::*;

  localparam int ADDR_W = 17;
  localparam int COL_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grid_loader_if #(.ADDR_W(ADDR_W), .COL_W(COL_W)) bus();

  grid_loader #(.ADDR_W(ADDR_W), .COL_W(COL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {bit wr; int addr; bit val;} beat_exp_t;
  typedef struct {int addr; bit val; int cyc;} wr_exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gap_max = 0;

  wr_exp_t    sb[$];
  wr_exp_t    mon_e;
  logic [7:0] stim[$];
  beat_exp_t  m_beats[$];
  bit         m_done, m_err;
  int         m_w, m_h;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (bus.write_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0h val=%0d required=no write (cycle %0d)",
                 bus.write_addr, bus.write_val, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("write_addr", bus.write_addr, mon_e.addr);
        check("write_val", bus.write_val, mon_e.val);
        check("write_cycle", cyc, mon_e.cyc);
      end
    end else if (bus.write_en !== 1'b0) begin
      check("write_en_known", bus.write_en, 0);
    end
  end

  // Reference: cells gather into the current row; a row is committed on
  // newline (or end of stream) and its length fixes or is checked against the width.
  task automatic model();
    int len = 0, rows = 0, width = 0;
    bit known = 0, err = 0;
    m_beats.delete();
    m_done = 0;
    m_err = 0;
    for (int i = 0; i < stim.size(); i++) begin
      beat_exp_t b = '{0, 0, 0};
      logic [7:0] c = stim[i];
      bit last = (i == stim.size() - 1);
      if (c == "@" || c == ".") begin
        if (len == 255 || (known && len == width) || rows >= 512) err = 1;
        else begin
          b.wr = 1;
          b.addr = rows * 256 + len;
          b.val = (c == "@");
          len++;
        end
      end else if (c != "\n" && c != "\r") begin
        err = 1;
      end
      if (!err && len > 0 && (c == "\n" || last)) begin
        if (!known) begin
          width = len;
          known = 1;
        end else if (len != width) err = 1;
        if (!err) begin
          rows++;
          len = 0;
        end
      end
      m_beats.push_back(b);
      if (err) begin
        m_err = 1;
        break;
      end
      if (last) begin
        m_done = 1;
        break;
      end
    end
    m_w = width;
    m_h = rows;
  endtask

  task automatic add(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'(($urandom));
    bus.in_data  = 8'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_error"}, bus.error, 0);
    check({tag, "_write_en"}, bus.write_en, 0);
    check({tag, "_write_addr"}, bus.write_addr, 0);
    check({tag, "_write_val"}, bus.write_val, 0);
    check({tag, "_width"}, bus.width, 0);
    check({tag, "_height"}, bus.height, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");
  endtask

  task automatic send_beat(input logic [7:0] ch, input bit last, input beat_exp_t b);
    repeat ($urandom_range(0, gap_max)) @(negedge clk);
    bus.in_data  = ch;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    check("in_ready_load", bus.in_ready, 1);
    if (b.wr) sb.push_back('{b.addr, b.val, cyc + 1});
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic run_stream(input string tag);
    model();
    for (int i = 0; i < m_beats.size(); i++)
      send_beat(stim[i], i == stim.size() - 1, m_beats[i]);
    check({tag, "_done"}, bus.done, m_done);
    check({tag, "_error"}, bus.error, m_err);
    bus.in_valid = 1'b1;
    bus.in_data  = CH_ROLL;
    bus.in_last  = 1'b1;
    repeat (3) begin
      check({tag, "_in_ready_held"}, bus.in_ready, 0);
      @(negedge clk);
    end
    idle_inputs();
    check({tag, "_width"}, bus.width, m_w);
    check({tag, "_height"}, bus.height, m_h);
    check({tag, "_done_held"}, bus.done, m_done);
    check({tag, "_error_held"}, bus.error, m_err);
    check({tag, "_writes_left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic gen_random();
    int w = $urandom_range(1, 8);
    int h = $urandom_range(1, 5);
    int bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, h - 1) : -1;
    stim.delete();
    for (int r = 0; r < h; r++) begin
      int n = w;
      if (r == bad) n = (w > 1 && $urandom_range(0, 1) == 1) ? w - 1 : w + 1;
      for (int c = 0; c < n; c++) stim.push_back($urandom_range(0, 1) == 1 ? CH_ROLL : CH_EMPTY);
      if ($urandom_range(0, 2) == 0) stim.push_back(CH_CR);
      if (r < h - 1 || $urandom_range(0, 1) == 1) stim.push_back(CH_NL);
      if ($urandom_range(0, 3) == 0) stim.push_back(CH_NL);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_exp_t b0;
    idle_inputs();
    do_reset();

    stim.delete(); add("@.@\n.@@\n");              run_stream("basic");
    do_reset(); stim.delete(); add("@.@\n.@@");     run_stream("no_trailing_nl");
    do_reset(); stim.delete(); add("@.@\r\n.@@\r\n\n"); run_stream("crlf_blank");
    do_reset(); stim.delete(); add("@.@\n@@\n");    run_stream("short_row");
    do_reset(); stim.delete(); add("@.@\n.@@@\n");  run_stream("long_row");
    do_reset(); stim.delete(); add("@.x@\n");       run_stream("bad_byte");
    do_reset(); stim.delete(); add("\n");           run_stream("empty");
    do_reset(); stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(CH_EMPTY);
    stim.push_back(CH_NL);
    run_stream("row_256");
    do_reset(); stim.delete();
    for (int i = 0; i < 512; i++) add("@\n");
    add("@");
    run_stream("row_overflow");

    // Reset while a beat is offered must drop that beat's write.
    do_reset();
    b0 = '{1, 0, 0};
    send_beat(CH_EMPTY, 1'b0, b0);
    bus.in_data  = CH_ROLL;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    check_reset_state("midrst");
    check("midrst_writes_left", sb.size(), 0);
    stim.delete(); add("..\n"); run_stream("after_reset");

    gap_max = 3;
    for (int t = 0; t < 3; t++) begin
      do_reset(); stim.delete(); add("@.@\n.@@\n"); run_stream("basic_gaps");
    end
    for (int t = 0; t < 14; t++) begin
      do_reset(); gen_random(); run_stream("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_loader.md
Name: grid_loader

Overview:
Byte-stream parser that sits directly upstream of the 1-bit simple dual-port grid RAM. It consumes ASCII puzzle input one character per beat: '@' is an occupied cell, '.' is an empty cell, '\n' ends a row. It drives the RAM write port with one bit per cell at address {row, col}. It also reports the measured grid width/height to downstream scan stages and flags malformed input.

Parameters:
ADDR_W, 17, RAM address width; must match the grid RAM instance.
COL_W, 8, column field width; row field width ROW_W = ADDR_W - COL_W (9).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  8  ASCII character
in_valid  input  1  in_data valid this cycle
in_last  input  1  qualifies final beat of the stream (with in_valid)
in_ready  output  1  loader accepts a beat when in_valid & in_ready
write_addr  output  ADDR_W  RAM write address {row[ROW_W-1:0], col[COL_W-1:0]}
write_val  output  1  cell bit: 1 = '@', 0 = '.'
write_en  output  1  RAM write strobe
width  output  COL_W+1  columns per row; valid when done
height  output  ROW_W+1  row count; valid when done
done  output  1  sticky; grid fully loaded
error  output  1  sticky; malformed input, load aborted

Behaviour:
- Reset (rst_n low at a clk edge): state=LOAD; col=0, row=0, width=0, height=0, width_known=0. Outputs: write_en=0, write_addr=0, write_val=0, done=0, error=0, in_ready=1. Reset is honoured mid-load. Any pending write_en is dropped. RAM contents are not cleared.
- States: LOAD, DONE, ERROR. in_ready=1 only in LOAD. DONE and ERROR are held until reset; beats offered there are not accepted.
- Accepted beat = in_valid & in_ready. Write outputs are registered: one-cycle latency from the accepted beat to write_en, with matching addr/val. write_en is high for exactly one cycle per accepted cell character.
- '@' or '.': write to {row, col}; then col+1.
  - If col == 2**COL_W - 1 before the write: no write, go to ERROR.
  - If width_known and col == width before the write: no write, go to ERROR.
- '\n' with col == 0: ignored. Blank lines are not rows.
- '\n' with col > 0:
  - If !width_known: width=col, width_known=1.
  - Else if col != width: go to ERROR.
  - Otherwise height=row+1, row+1, col=0.
  - If row was already 2**ROW_W - 1: height is updated, then ERROR if any further cell character arrives (row field would wrap).
- '\r': ignored (no write, no counter change).
- Any other byte: go to ERROR, no write.
- in_last on an accepted beat:
  - First process the character as above.
  - If col > 0 after processing (unterminated last row), apply the same row-close rules as '\n'.
  - Then go to DONE (or ERROR if row-close failed).
  - done asserts in the cycle after the last beat, coincident with that beat's write_en.
- in_last with no rows at all: DONE with width=0, height=0.
- ERROR: error=1, done=0, no further writes. width/height hold their last values.
- Arithmetic: col counter COL_W+1 bits, row counter ROW_W+1 bits; overflow checks use these extra bits. The address is formed by concatenation, not multiplication. Row stride is 2**COL_W.

Decomposition:
- Shared package: ASCII constants (CH_ROLL=8'h40, CH_EMPTY=8'h2E, CH_NL=8'h0A, CH_CR=8'h0D), state enum {LOAD, DONE, ERROR}, COL_W/ROW_W derivation.
- No sub-module needed. Optional `ascii_classify` combinational helper, inlined acceptable.
- Top level instantiates grid_loader feeding the grid RAM write port.

Test Plan:
- Stream "@.@\n.@@\n" with in_last on the final '\n'. Expected:
  - writes (addr,val) = (0x00000,1), (0x00001,0), (0x00002,1), (0x00100,0), (0x00101,1), (0x00102,1), each one cycle after its beat;
  - width=3, height=2, done=1, error=0.
- Same grid without the trailing '\n' (in_last on the final '@'), plus "\r\n" line endings and a trailing blank line variant -> identical writes, width=3, height=2, done=1.
- Second row "@@" after first row "@.@" -> no write for the second row's '\n'; error=1, done=0, in_ready=0; width=3 held.
- Byte 'x' (8'h78) mid-row, or 256 cells in one row -> no write for the offending beat, error=1 the next cycle, subsequent beats not accepted.
- rst_n low for one cycle mid-row, then "..\n" with in_last -> no stale write_en after reset; writes at 0x00000 and 0x00001 with val 0; width=2, height=1, done=1.
- in_valid toggled randomly (gaps) on the first grid -> same write sequence; write_en only follows accepted beats.
